ysyx_210544_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard that drives the single write port (rd, rd_wen, rd_data) of the integer register file. It merges single-cycle results from the main pipeline with results from long-latency units (mul/div) over a valid/ready handshake. It tracks destination registers reserved by in-flight long operations so decode can stall on RAW/WAW hazards. It sits between the MEM/WB pipeline stage and the register file write port; the difftest register view is taken from the register file, not from this block.

---
 rtl/ysyx_210544_wb_arbiter_pkg.sv | 15 +
 rtl/ysyx_210544_wb_arbiter_if.sv | 40 ++++
 rtl/ysyx_210544_wb_arbiter.sv | 81 ++++++++
 tb/tb_ysyx_210544_wb_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_210544_wb_arbiter_pkg.sv
// Shared widths and types for the register-file write-back arbiter.
package ysyx_210544_wb_arbiter_pkg;
  localparam int BUS_64      = 64;
  localparam int BUS_RIDX    = 5;
  localparam int WB_STARVE_W = 4;
  localparam logic [BUS_64-1:0] ZERO_WORD = '0;

  typedef logic [BUS_64-1:0]   word_t;
  typedef logic [BUS_RIDX-1:0] ridx_t;

  typedef struct packed {
    ridx_t rd;
    word_t data;
  } wb_t;
endpackage

// File: rtl/ysyx_210544_wb_arbiter_if.sv
// Issue, source query, pipeline, long-unit and register-file write signals of the arbiter.
interface ysyx_210544_wb_arbiter_if;
  import ysyx_210544_wb_arbiter_pkg::*;

  logic  i_iss_valid;
  ridx_t i_iss_rd;
  logic  o_iss_ready;
  ridx_t i_rs1;
  ridx_t i_rs2;
  logic  o_rs1_busy;
  logic  o_rs2_busy;
  logic  i_pipe_valid;
  ridx_t i_pipe_rd;
  word_t i_pipe_data;
  logic  o_pipe_stall;
  logic  i_long_valid;
  ridx_t i_long_rd;
  word_t i_long_data;
  logic  o_long_ready;
  ridx_t o_rd;
  logic  o_rd_wen;
  word_t o_rd_data;
  logic  o_waw_err;

  modport slave (
    input  i_iss_valid, i_iss_rd, i_rs1, i_rs2,
    input  i_pipe_valid, i_pipe_rd, i_pipe_data,
    input  i_long_valid, i_long_rd, i_long_data,
    output o_iss_ready, o_rs1_busy, o_rs2_busy, o_pipe_stall, o_long_ready,
    output o_rd, o_rd_wen, o_rd_data, o_waw_err
  );

  modport master (
    output i_iss_valid, i_iss_rd, i_rs1, i_rs2,
    output i_pipe_valid, i_pipe_rd, i_pipe_data,
    output i_long_valid, i_long_rd, i_long_data,
    input  o_iss_ready, o_rs1_busy, o_rs2_busy, o_pipe_stall, o_long_ready,
    input  o_rd, o_rd_wen, o_rd_data, o_waw_err
  );
endinterface

// File: rtl/ysyx_210544_wb_arbiter.sv
// Write-back arbiter + busy scoreboard: 1-cycle accept-to-write latency; pipe wins unless a
// long result has been refused STARVE_MAX cycles, then the pipe is stalled for one cycle.
module ysyx_210544_wb_arbiter
  import ysyx_210544_wb_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic rst,
  ysyx_210544_wb_arbiter_if.slave bus
);

  logic [31:0]            busy_q, busy_d;
  logic [WB_STARVE_W-1:0] cnt_q, cnt_d;
  logic                   stall_q, stall_d;
  wb_t                    wb_q, wb_d;
  logic                   wen_q, wen_d;
  logic                   waw_q, waw_d;

  logic iss_fire, long_fire, pipe_acc, long_ready;

  assign long_ready = stall_q | ~bus.i_pipe_valid;
  assign long_fire  = bus.i_long_valid & long_ready;
  assign pipe_acc   = bus.i_pipe_valid & ~stall_q;
  assign iss_fire   = bus.i_iss_valid & bus.o_iss_ready;

  assign bus.o_iss_ready  = (bus.i_iss_rd == '0) | ~busy_q[bus.i_iss_rd];
  assign bus.o_rs1_busy   = busy_q[bus.i_rs1];
  assign bus.o_rs2_busy   = busy_q[bus.i_rs2];
  assign bus.o_long_ready = long_ready;
  assign bus.o_pipe_stall = stall_q;
  assign bus.o_rd         = wb_q.rd;
  assign bus.o_rd_data    = wb_q.data;
  assign bus.o_rd_wen     = wen_q;
  assign bus.o_waw_err    = waw_q;

  always_comb begin
    busy_d = busy_q;
    if (long_fire) busy_d[bus.i_long_rd] = 1'b0;
    // An issue reserving the index being released this cycle keeps it reserved.
    if (iss_fire)  busy_d[bus.i_iss_rd]  = 1'b1;
    busy_d[0] = 1'b0;

    cnt_d = cnt_q;
    if (long_fire)             cnt_d = '0;
    else if (bus.i_long_valid) cnt_d = cnt_q + 1'b1;
    // Comparing the next count makes the stall land on the cycle right after the last refusal.
    stall_d = (cnt_d == WB_STARVE_W'(STARVE_MAX));

    wb_d  = wb_q;
    wen_d = 1'b0;
    if (pipe_acc) begin
      wb_d  = '{rd: bus.i_pipe_rd, data: bus.i_pipe_data};
      wen_d = (bus.i_pipe_rd != '0);
    end else if (long_fire) begin
      wb_d  = '{rd: bus.i_long_rd, data: bus.i_long_data};
      wen_d = (bus.i_long_rd != '0);
    end

    waw_d = waw_q | (pipe_acc & (bus.i_pipe_rd != '0) & busy_q[bus.i_pipe_rd]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= '0;
      cnt_q   <= '0;
      stall_q <= 1'b0;
      wb_q    <= '{rd: '0, data: ZERO_WORD};
      wen_q   <= 1'b0;
      waw_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      wb_q    <= wb_d;
      wen_q   <= wen_d;
      waw_q   <= waw_d;
    end
  end

endmodule

// File: tb/tb_ysyx_210544_wb_arbiter.sv
// Directed and randomized bench for the write-back arbiter against a reservation-set model.
module tb_ysyx_210544_wb_arbiter;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ysyx_210544_wb_arbiter_if ifc ();

  ysyx_210544_wb_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: set of reserved registers, refused-cycle count, last write.
  bit          m_busy [32];
  int          m_wait;
  bit          m_stall;
  logic [4:0]  m_rd;
  bit          m_wen;
  logic [63:0] m_data;
  bit          m_waw;
  bit          last_lfire, last_ifire;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_wait = 0; m_stall = 0; m_rd = '0; m_wen = 0; m_data = '0; m_waw = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".rd"},    64'(ifc.o_rd), 64'(m_rd));
    chk({tag, ".wen"},   64'(ifc.o_rd_wen), 64'(m_wen));
    chk({tag, ".data"},  ifc.o_rd_data, m_data);
    chk({tag, ".waw"},   64'(ifc.o_waw_err), 64'(m_waw));
    chk({tag, ".stall"}, 64'(ifc.o_pipe_stall), 64'(m_stall));
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check registers.
  task automatic cycle(input string tag,
                       input bit pv, input logic [4:0] prd, input logic [63:0] pdata,
                       input bit lv, input logic [4:0] lrd, input logic [63:0] ldata,
                       input bit iv, input logic [4:0] ird,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    bit exp_lr, exp_ir, pacc, lfire, ifire;
    ifc.i_pipe_valid = pv;  ifc.i_pipe_rd = prd;  ifc.i_pipe_data = pdata;
    ifc.i_long_valid = lv;  ifc.i_long_rd = lrd;  ifc.i_long_data = ldata;
    ifc.i_iss_valid  = iv;  ifc.i_iss_rd  = ird;
    ifc.i_rs1 = rs1; ifc.i_rs2 = rs2;
    #1;
    exp_lr = m_stall || !pv;
    exp_ir = (ird == 0) || !m_busy[ird];
    chk({tag, ".long_ready"}, 64'(ifc.o_long_ready), 64'(exp_lr));
    chk({tag, ".iss_ready"},  64'(ifc.o_iss_ready), 64'(exp_ir));
    chk({tag, ".rs1_busy"},   64'(ifc.o_rs1_busy), 64'(m_busy[rs1]));
    chk({tag, ".rs2_busy"},   64'(ifc.o_rs2_busy), 64'(m_busy[rs2]));

    pacc  = pv && !m_stall;
    lfire = lv && exp_lr;
    ifire = iv && exp_ir;
    if (pacc && prd != 0 && m_busy[prd]) m_waw = 1;
    if (lfire) m_busy[lrd] = 0;
    if (ifire && ird != 0) m_busy[ird] = 1;
    if (lfire) m_wait = 0;
    else if (lv) m_wait = m_wait + 1;
    m_stall = (m_wait == STARVE_MAX);
    if (pacc) begin
      m_rd = prd; m_data = pdata; m_wen = (prd != 0);
    end else if (lfire) begin
      m_rd = lrd; m_data = ldata; m_wen = (lrd != 0);
    end else begin
      m_wen = 0;
    end
    last_lfire = lfire;
    last_ifire = ifire;

    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  task automatic idle(input string tag, input logic [4:0] rs1);
    cycle(tag, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 0, 5'd0, rs1, 5'd0);
  endtask

  bit          lv_hold;
  bit          pv_r, lv_r, iv_r;
  logic [4:0]  prd_r, lrd_r, ird_r;
  logic [63:0] pdata_r, ldata_r;
  int          q[$];
  int          n_wait;

  initial begin
    model_reset();
    ifc.i_pipe_valid = 0; ifc.i_pipe_rd = '0; ifc.i_pipe_data = '0;
    ifc.i_long_valid = 0; ifc.i_long_rd = '0; ifc.i_long_data = '0;
    ifc.i_iss_valid = 0;  ifc.i_iss_rd = '0;  ifc.i_rs1 = '0; ifc.i_rs2 = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    check_regs("reset");

    // Pipe only
    cycle("pipe5", 1, 5'd5, 64'h1234, 0, 5'd0, 64'd0, 0, 5'd0, 5'd0, 5'd0);
    chk("pipe5.rd_const",   64'(ifc.o_rd), 64'd5);
    chk("pipe5.wen_const",  64'(ifc.o_rd_wen), 64'd1);
    chk("pipe5.data_const", ifc.o_rd_data, 64'h1234);
    cycle("pipe0", 1, 5'd0, 64'h55, 0, 5'd0, 64'd0, 0, 5'd0, 5'd0, 5'd0);
    chk("pipe0.wen_const", 64'(ifc.o_rd_wen), 64'd0);

    // Long round trip on x10
    cycle("iss10", 0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 1, 5'd10, 5'd10, 5'd0);
    cycle("iss10_again", 0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 1, 5'd10, 5'd10, 5'd0);
    chk("iss10.busy_const", 64'(ifc.o_rs1_busy), 64'd1);
    chk("iss10.ready_const", 64'(ifc.o_iss_ready), 64'd0);
    cycle("long10", 0, 5'd0, 64'd0, 1, 5'd10, 64'hdead, 0, 5'd0, 5'd10, 5'd0);
    chk("long10.data_const", ifc.o_rd_data, 64'hdead);
    idle("long10_cleared", 5'd10);
    chk("long10.cleared_const", 64'(ifc.o_rs1_busy), 64'd0);

    // Collision: pipe x3 wins over long x7, long follows
    cycle("coll_pipe", 1, 5'd3, 64'h33, 1, 5'd7, 64'h77, 0, 5'd0, 5'd0, 5'd0);
    chk("coll_pipe.rd_const", 64'(ifc.o_rd), 64'd3);
    cycle("coll_long", 0, 5'd0, 64'd0, 1, 5'd7, 64'h77, 0, 5'd0, 5'd0, 5'd0);
    chk("coll_long.rd_const", 64'(ifc.o_rd), 64'd7);

    // Starvation: continuous pipe traffic, long x7 waiting
    n_wait = 0;
    for (int i = 0; i < 10; i++) begin
      cycle("starve", 1, 5'(i + 1), 64'(i), 1, 5'd7, 64'hbeef, 0, 5'd0, 5'd0, 5'd0);
      n_wait++;
      if (last_lfire) break;
    end
    chk("starve.wait_cycles", 64'(n_wait), 64'(STARVE_MAX + 1));
    chk("starve.rd_const", 64'(ifc.o_rd), 64'd7);
    chk("starve.stall_dropped", 64'(ifc.o_pipe_stall), 64'd0);
    cycle("starve_after", 1, 5'd2, 64'h22, 0, 5'd0, 64'd0, 0, 5'd0, 5'd0, 5'd0);
    chk("starve_after.rd_const", 64'(ifc.o_rd), 64'd2);

    // Same-cycle release and reservation of x9, then pipe WAW on x9
    cycle("sim9", 0, 5'd0, 64'd0, 1, 5'd9, 64'h99, 1, 5'd9, 5'd9, 5'd0);
    idle("sim9_busy", 5'd9);
    chk("sim9.busy_const", 64'(m_busy[9]), 64'd1);
    cycle("waw9", 1, 5'd9, 64'h999, 0, 5'd0, 64'd0, 0, 5'd0, 5'd0, 5'd0);
    chk("waw9.err_const", 64'(ifc.o_waw_err), 64'd1);
    idle("waw9_sticky", 5'd0);

    // Asynchronous reset mid-operation
    cycle("pre_rst_iss", 0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 1, 5'd11, 5'd0, 5'd0);
    cycle("pre_rst_long", 1, 5'd2, 64'h2, 1, 5'd11, 64'hab, 0, 5'd0, 5'd11, 5'd9);
    #2 rst = 1'b0;
    #1;
    chk("arst.rd",    64'(ifc.o_rd), 64'd0);
    chk("arst.wen",   64'(ifc.o_rd_wen), 64'd0);
    chk("arst.data",  ifc.o_rd_data, 64'd0);
    chk("arst.waw",   64'(ifc.o_waw_err), 64'd0);
    chk("arst.stall", 64'(ifc.o_pipe_stall), 64'd0);
    chk("arst.rs1",   64'(ifc.o_rs1_busy), 64'd0);
    chk("arst.rs2",   64'(ifc.o_rs2_busy), 64'd0);
    ifc.i_pipe_valid = 0; ifc.i_long_valid = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    check_regs("post_rst");

    // Randomized traffic with an in-order long unit
    lv_hold = 0; q.delete();
    pv_r = 0; prd_r = '0; pdata_r = '0; lv_r = 0; lrd_r = '0; ldata_r = '0;
    for (int c = 0; c < 400; c++) begin
      if (!m_stall) begin
        pv_r = ($urandom_range(0, 2) != 0);
        prd_r = 5'($urandom_range(0, 31));
        pdata_r = {$urandom, $urandom};
      end
      if (!lv_hold) begin
        if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
          lv_r = 1; lrd_r = 5'(q[0]); ldata_r = {$urandom, $urandom}; lv_hold = 1;
        end else begin
          lv_r = 0;
        end
      end
      iv_r  = ($urandom_range(0, 3) == 0);
      ird_r = 5'($urandom_range(0, 31));
      cycle("rand", pv_r, prd_r, pdata_r, lv_r, lrd_r, ldata_r, iv_r, ird_r,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if (last_lfire) begin
        void'(q.pop_front());
        lv_hold = 0;
        lv_r = 0;
      end
      if (last_ifire) q.push_back(int'(ird_r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
